// File: rtl/demux_tdm_pkg.sv
// Shared types and defaults for the two-channel TDM receiver.
package demux_tdm_pkg;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    CH_A = 2'd1,
    CH_B = 2'd2
  } state_e;

  localparam int W_DEFAULT = 4;

endpackage : demux_tdm_pkg

// File: rtl/demux_tdm_sipo_reg.sv
// W-bit serial-in/parallel-out register; load restarts it with a single bit,
// shift appends at the LSB so the oldest bit ends up as the MSB.
module sipo_reg
  import demux_tdm_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en_i,
  input  logic         load_i,
  input  logic         bit_i,
  output logic [W-1:0] data_o
);

  logic [W-1:0] data_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= '0;
    end else if (load_i) begin
      data_q <= {{(W-1){1'b0}}, bit_i};
    end else if (en_i) begin
      data_q <= {data_q[W-2:0], bit_i};
    end
  end

  assign data_o = data_q;

endmodule : sipo_reg

// File: rtl/demux_tdm.sv
// Receive side of the two-channel TDM link: locks onto sync-marked frames and
// rebuilds one word per channel per frame, each with a one-cycle strobe.
module demux_tdm
  import demux_tdm_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         din,
  input  logic         din_valid,
  input  logic         sync,
  output logic [W-1:0] a_word,
  output logic         a_valid,
  output logic [W-1:0] b_word,
  output logic         b_valid,
  output logic         frame_err,
  output logic         locked
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LastBit = CW'(W - 1);

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   a_word_q, a_word_d;
  logic [W-1:0]   b_word_q, b_word_d;
  logic           a_valid_q, a_valid_d;
  logic           b_valid_q, b_valid_d;
  logic           frame_err_q, frame_err_d;
  logic           locked_q, locked_d;
  logic           shift_en, load_first;
  logic [W-1:0]   sr;
  logic [W-1:0]   completed;

  sipo_reg #(.W(W)) u_sipo (
    .clk    (clk),
    .reset  (reset),
    .en_i   (shift_en),
    .load_i (load_first),
    .bit_i  (din),
    .data_o (sr)
  );

  // The word completes on the same edge its last bit is shifted in, so it is
  // assembled from the register contents plus the incoming bit.
  assign completed = {sr[W-2:0], din};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_word_d    = a_word_q;
    b_word_d    = b_word_q;
    a_valid_d   = 1'b0;
    b_valid_d   = 1'b0;
    frame_err_d = 1'b0;
    locked_d    = locked_q;
    shift_en    = 1'b0;
    load_first  = 1'b0;

    if (din_valid) begin
      if (sync) begin
        // Any sync starts a new frame; one arriving mid-frame is a violation.
        if (state_q != HUNT) begin
          frame_err_d = 1'b1;
          locked_d    = 1'b0;
        end
        load_first = 1'b1;
        cnt_d      = CW'(1);
        state_d    = CH_A;
      end else begin
        case (state_q)
          HUNT: begin
            if (locked_q) begin
              frame_err_d = 1'b1;
              locked_d    = 1'b0;
            end
          end
          CH_A, CH_B: begin
            shift_en = 1'b1;
            if (cnt_q == LastBit) begin
              cnt_d = '0;
              if (state_q == CH_A) begin
                a_word_d  = completed;
                a_valid_d = 1'b1;
                state_d   = CH_B;
              end else begin
                b_word_d  = completed;
                b_valid_d = 1'b1;
                locked_d  = 1'b1;
                state_d   = HUNT;
              end
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
          default: state_d = HUNT;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= HUNT;
      cnt_q       <= '0;
      a_word_q    <= '0;
      b_word_q    <= '0;
      a_valid_q   <= 1'b0;
      b_valid_q   <= 1'b0;
      frame_err_q <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_word_q    <= a_word_d;
      b_word_q    <= b_word_d;
      a_valid_q   <= a_valid_d;
      b_valid_q   <= b_valid_d;
      frame_err_q <= frame_err_d;
      locked_q    <= locked_d;
    end
  end

  assign a_word    = a_word_q;
  assign b_word    = b_word_q;
  assign a_valid   = a_valid_q;
  assign b_valid   = b_valid_q;
  assign frame_err = frame_err_q;
  assign locked    = locked_q;

endmodule : demux_tdm

// File: doc/demux_tdm.md
# demux_tdm

Receive end of the two-channel time-division link: the transmit side multiplexes channel A (select = 0) and channel B (select = 1) onto one serial line. This block takes that serial bit stream and the frame sync marker, and locks onto frames. It rebuilds one W-bit word per channel per frame and presents each word with a one-cycle valid strobe. It sits between the serial line and the two channel consumers.

## Interface
- W, 4, bits per channel slot; legal range W >= 2.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- din  input  1  serial data bit, MSB of each slot first.
- din_valid  input  1  din (and sync) sampled only when 1.
- sync  input  1  marks the first bit of a frame, i.e. MSB of the channel A slot.
- a_word  output  W  last complete channel A word.
- a_valid  output  1  one-cycle strobe: a_word just updated.
- b_word  output  W  last complete channel B word.
- b_valid  output  1  one-cycle strobe: b_word just updated.
- frame_err  output  1  one-cycle strobe on a framing violation.
- locked  output  1  high while frames are being received correctly.

## Operation
- Frame: 2*W valid bits. The first W bits form the A slot, the next W bits the B slot. sync is high on the first bit only.
- States:
  - HUNT: wait for a frame start.
  - CH_A: shifting the A slot.
  - CH_B: shifting the B slot.
- Bit counter: width clog2(W), counts valid bits within the current slot.
- Shift register: W bits, shared between the two slots. Each new bit enters at the LSB, so the first bit ends up as the MSB.
- HUNT:
  - din_valid & sync: shift in din, counter = 1, go to CH_A.
  - din_valid & !sync: discard the bit. If locked = 1, pulse frame_err and clear locked.
- CH_A, valid bit with !sync: shift in the bit.
  - Counter == W-1 (last bit): a_word <= completed word, pulse a_valid, counter = 0, go to CH_B.
  - Otherwise: counter + 1.
- CH_B, valid bit with !sync: same as CH_A, but drives b_word / b_valid.
  - On the last bit: set locked = 1 and go to HUNT. The next frame must start with sync.
- sync in the middle of a frame (din_valid & sync in CH_A or CH_B):
  - pulse frame_err and clear locked;
  - drop the partial word (no valid strobe);
  - treat the bit as the first bit of a new frame: shift register = din, counter = 1, go to CH_A.
- din_valid = 0: state, counter, shift register and outputs all hold. Gaps of any length are legal.
- a_word and b_word keep their value until the next completed slot. Strobes are never asserted together.

## Timing
- Reset (asynchronous, active-high), effective immediately:
  - state = HUNT, counter = 0, shift register = 0;
  - a_word = 0, b_word = 0;
  - a_valid, b_valid, frame_err, locked = 0.
- Reset asserted mid-frame discards the partial word. No strobe is produced.
- All outputs are registered. Latency from the rising edge that samples a slot's last bit:
  - the word and its strobe are visible right after that edge;
  - the strobe stays high for exactly one cycle.
- frame_err is visible right after the edge that samples the offending bit, for one cycle.
- Back-to-back frames with din_valid held high: a_valid and b_valid each pulse once per 2*W cycles, W cycles apart.
- locked rises in the same cycle as the b_valid of the first complete frame. It falls in the same cycle as frame_err.

## Structure
- Package demux_tdm_pkg holds:
  - the state enum (HUNT, CH_A, CH_B);
  - the default value of W.
- One natural sub-module: sipo_reg. It is a W-bit serial-in/parallel-out shift register with enable and synchronous load-first-bit. The FSM, counter and output registers live in demux_tdm.

## Test plan
- Reset check: assert reset mid-simulation with no clock edge -> every output reads 0 immediately; state returns to HUNT.
- Clean frame, W=4: bits 1,0,1,1,0,1,1,0 (sync on the first bit), din_valid held high -> a_word = 4'b1011 with a_valid after the 4th edge; b_word = 4'b0110 with b_valid after the 8th edge; locked = 1; no frame_err.
- Gapped stream: the same frame with din_valid low for 3 cycles between bits 2 and 3 -> identical words and strobes, each delayed by 3 cycles; outputs hold during the gap.
- Early sync: frame start, then sync asserted again on bit 3 -> frame_err pulse; no a_valid; the new frame 0,0,1,1,1,1,0,0 decodes as a_word = 4'b0011, b_word = 4'b1100.
- Missing sync after lock: after one good frame, send 8 bits without sync -> frame_err on the first of those bits; locked = 0; no strobes; a_word and b_word keep their old values.
- Two back-to-back frames (A=4'hF, B=4'h0, then A=4'h5, B=4'hA) -> four strobes at edges 4, 8, 12, 16 with those values in that order.
